// File: rtl/ara_pkg.sv
// Shared widths and record types for the lane result-write path into the VRF banks.
package ara_pkg;

  localparam int unsigned NrBanks    = 8;
  localparam int unsigned VaddrWidth = 12;
  localparam int unsigned DataWidth  = 64;
  localparam int unsigned NrVInsn    = 8;
  localparam int unsigned BankSelW   = $clog2(NrBanks);
  localparam int unsigned RowW       = VaddrWidth - BankSelW;
  localparam int unsigned VidW       = $clog2(NrVInsn);
  localparam int unsigned BeW        = DataWidth / 8;

  typedef logic [VidW-1:0] vid_t;

  typedef struct packed {
    vid_t                  id;
    logic [VaddrWidth-1:0] addr;
    logic [DataWidth-1:0]  wdata;
    logic [BeW-1:0]        be;
  } result_req_t;

  typedef struct packed {
    logic [RowW-1:0]      row;
    logic [DataWidth-1:0] data;
    logic [BeW-1:0]       be;
    vid_t                 id;
  } bank_wr_t;

  // The low address bits only select the bank; the bank itself sees the row.
  function automatic bank_wr_t to_bank_wr(input result_req_t req);
    bank_wr_t wr;
    wr.row  = req.addr[VaddrWidth-1:BankSelW];
    wr.data = req.wdata;
    wr.be   = req.be;
    wr.id   = req.id;
    return wr;
  endfunction

endpackage

// File: rtl/vrf_wb_bank_slot.sv
// One-entry write buffer for a single VRF bank plus its ALU/MFPU round-robin pointer.
module vrf_wb_bank_slot
  import ara_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     alu_hit_i,
  input  logic     mfpu_hit_i,
  input  bank_wr_t alu_wr_i,
  input  bank_wr_t mfpu_wr_i,
  input  logic     ready_i,
  output logic     alu_gnt_o,
  output logic     mfpu_gnt_o,
  output logic     wr_req_o,
  output bank_wr_t wr_o,
  output logic     commit_o
);

  logic     r_valid;
  logic     r_rr;
  bank_wr_t r_entry;

  logic w_can_load;
  logic w_alu_win;
  logic w_mfpu_win;
  logic w_alu_gnt;
  logic w_mfpu_gnt;

  // A full entry that drains this cycle can refill in the same cycle.
  assign w_can_load = (~r_valid | ready_i) & ~rst_i;
  assign w_alu_win  = alu_hit_i & (~mfpu_hit_i | ~r_rr);
  assign w_mfpu_win = mfpu_hit_i & (~alu_hit_i | r_rr);
  assign w_alu_gnt  = w_can_load & w_alu_win;
  assign w_mfpu_gnt = w_can_load & w_mfpu_win;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_rr    <= 1'b0;
      r_entry <= '0;
    end else if (w_alu_gnt || w_mfpu_gnt) begin
      r_valid <= 1'b1;
      r_entry <= w_alu_gnt ? alu_wr_i : mfpu_wr_i;
      if (alu_hit_i && mfpu_hit_i) begin
        r_rr <= ~r_rr;
      end
    end else if (ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign alu_gnt_o  = w_alu_gnt;
  assign mfpu_gnt_o = w_mfpu_gnt;
  assign wr_req_o   = r_valid;
  assign wr_o       = r_entry;
  assign commit_o   = r_valid & ready_i;

endmodule

// File: rtl/vrf_result_wb_arbiter.sv
// Accepts ALU and MFPU result writes, steers each to its VRF bank buffer and reports commits by ID.
module vrf_result_wb_arbiter
  import ara_pkg::*;
(
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 alu_result_req_i,
  input  logic [VidW-1:0]                      alu_result_id_i,
  input  logic [VaddrWidth-1:0]                alu_result_addr_i,
  input  logic [DataWidth-1:0]                 alu_result_wdata_i,
  input  logic [BeW-1:0]                       alu_result_be_i,
  output logic                                 alu_result_gnt_o,
  input  logic                                 mfpu_result_req_i,
  input  logic [VidW-1:0]                      mfpu_result_id_i,
  input  logic [VaddrWidth-1:0]                mfpu_result_addr_i,
  input  logic [DataWidth-1:0]                 mfpu_result_wdata_i,
  input  logic [BeW-1:0]                       mfpu_result_be_i,
  output logic                                 mfpu_result_gnt_o,
  output logic [NrBanks-1:0]                   bank_wr_req_o,
  output logic [NrBanks-1:0][RowW-1:0]         bank_wr_addr_o,
  output logic [NrBanks-1:0][DataWidth-1:0]    bank_wr_data_o,
  output logic [NrBanks-1:0][BeW-1:0]          bank_wr_be_o,
  input  logic [NrBanks-1:0]                   bank_wr_ready_i,
  output logic [NrVInsn-1:0]                   wr_commit_o
);

  result_req_t w_alu_req;
  result_req_t w_mfpu_req;
  bank_wr_t    w_alu_wr;
  bank_wr_t    w_mfpu_wr;
  logic [BankSelW-1:0] w_alu_bank;
  logic [BankSelW-1:0] w_mfpu_bank;

  logic [NrBanks-1:0] w_alu_gnt;
  logic [NrBanks-1:0] w_mfpu_gnt;
  logic [NrBanks-1:0] w_commit;
  bank_wr_t           w_slot_wr [NrBanks];
  logic [NrVInsn-1:0] w_commit_ids;

  assign w_alu_req  = '{id: alu_result_id_i, addr: alu_result_addr_i,
                        wdata: alu_result_wdata_i, be: alu_result_be_i};
  assign w_mfpu_req = '{id: mfpu_result_id_i, addr: mfpu_result_addr_i,
                        wdata: mfpu_result_wdata_i, be: mfpu_result_be_i};
  assign w_alu_wr    = to_bank_wr(w_alu_req);
  assign w_mfpu_wr   = to_bank_wr(w_mfpu_req);
  assign w_alu_bank  = alu_result_addr_i[BankSelW-1:0];
  assign w_mfpu_bank = mfpu_result_addr_i[BankSelW-1:0];

  for (genvar b = 0; b < NrBanks; b++) begin : g_bank
    vrf_wb_bank_slot u_slot (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .alu_hit_i  (alu_result_req_i && (w_alu_bank == BankSelW'(b))),
      .mfpu_hit_i (mfpu_result_req_i && (w_mfpu_bank == BankSelW'(b))),
      .alu_wr_i   (w_alu_wr),
      .mfpu_wr_i  (w_mfpu_wr),
      .ready_i    (bank_wr_ready_i[b]),
      .alu_gnt_o  (w_alu_gnt[b]),
      .mfpu_gnt_o (w_mfpu_gnt[b]),
      .wr_req_o   (bank_wr_req_o[b]),
      .wr_o       (w_slot_wr[b]),
      .commit_o   (w_commit[b])
    );

    assign bank_wr_addr_o[b] = w_slot_wr[b].row;
    assign bank_wr_data_o[b] = w_slot_wr[b].data;
    assign bank_wr_be_o[b]   = w_slot_wr[b].be;
  end

  assign alu_result_gnt_o  = |w_alu_gnt;
  assign mfpu_result_gnt_o = |w_mfpu_gnt;

  always_comb begin
    w_commit_ids = '0;
    for (int b = 0; b < NrBanks; b++) begin
      if (w_commit[b]) begin
        w_commit_ids[w_slot_wr[b].id] = 1'b1;
      end
    end
  end

  assign wr_commit_o = w_commit_ids;

endmodule

// File: tb/tb_vrf_result_wb_arbiter.sv
// Directed bench for vrf_result_wb_arbiter: per-cycle vector table plus data/row/be sequences.
module tb_vrf_result_wb_arbiter;
  import ara_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                              rst;
  logic                              a_req, m_req;
  logic [VidW-1:0]                   a_id, m_id;
  logic [VaddrWidth-1:0]             a_addr, m_addr;
  logic [DataWidth-1:0]              a_wdata, m_wdata;
  logic [BeW-1:0]                    a_be, m_be;
  logic                              a_gnt, m_gnt;
  logic [NrBanks-1:0]                bank_req;
  logic [NrBanks-1:0][RowW-1:0]      bank_addr;
  logic [NrBanks-1:0][DataWidth-1:0] bank_data;
  logic [NrBanks-1:0][BeW-1:0]       bank_be;
  logic [NrBanks-1:0]                rdy;
  logic [NrVInsn-1:0]                commit;

  vrf_result_wb_arbiter dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .alu_result_req_i    (a_req),
    .alu_result_id_i     (a_id),
    .alu_result_addr_i   (a_addr),
    .alu_result_wdata_i  (a_wdata),
    .alu_result_be_i     (a_be),
    .alu_result_gnt_o    (a_gnt),
    .mfpu_result_req_i   (m_req),
    .mfpu_result_id_i    (m_id),
    .mfpu_result_addr_i  (m_addr),
    .mfpu_result_wdata_i (m_wdata),
    .mfpu_result_be_i    (m_be),
    .mfpu_result_gnt_o   (m_gnt),
    .bank_wr_req_o       (bank_req),
    .bank_wr_addr_o      (bank_addr),
    .bank_wr_data_o      (bank_data),
    .bank_wr_be_o        (bank_be),
    .bank_wr_ready_i     (rdy),
    .wr_commit_o         (commit)
  );

  typedef struct {
    logic                  rst;
    logic                  a_req;
    logic [VidW-1:0]       a_id;
    logic [VaddrWidth-1:0] a_addr;
    logic                  m_req;
    logic [VidW-1:0]       m_id;
    logic [VaddrWidth-1:0] m_addr;
    logic [NrBanks-1:0]    rdy;
    logic                  e_ag;
    logic                  e_mg;
    logic [NrBanks-1:0]    e_req;
    logic [NrVInsn-1:0]    e_commit;
  } vec_t;

  vec_t vecs[$];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic logic [DataWidth-1:0] a_dat(input logic [VaddrWidth-1:0] addr);
    return 64'hA000_0000_0000_0000 | 64'(addr);
  endfunction

  function automatic logic [DataWidth-1:0] m_dat(input logic [VaddrWidth-1:0] addr);
    return 64'hB000_0000_0000_0000 | 64'(addr);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add(input logic r, input logic ar, input logic [VidW-1:0] ai,
                     input logic [VaddrWidth-1:0] aa, input logic mr,
                     input logic [VidW-1:0] mi, input logic [VaddrWidth-1:0] ma,
                     input logic [NrBanks-1:0] rd, input logic eag, input logic emg,
                     input logic [NrBanks-1:0] erq, input logic [NrVInsn-1:0] ec);
    vec_t v;
    v = '{rst: r, a_req: ar, a_id: ai, a_addr: aa, m_req: mr, m_id: mi, m_addr: ma,
          rdy: rd, e_ag: eag, e_mg: emg, e_req: erq, e_commit: ec};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic ar, input logic [VidW-1:0] ai,
                       input logic [VaddrWidth-1:0] aa, input logic [BeW-1:0] abe,
                       input logic mr, input logic [VidW-1:0] mi,
                       input logic [VaddrWidth-1:0] ma, input logic [NrBanks-1:0] rd);
    rst = r; a_req = ar; a_id = ai; a_addr = aa; a_wdata = a_dat(aa); a_be = abe;
    m_req = mr; m_id = mi; m_addr = ma; m_wdata = m_dat(ma); m_be = 8'hFF; rdy = rd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, 8'hFF, 1'b0, '0, '0, 8'hFF);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Test 1: different banks in parallel
    add(1, 1, 1, 12'h010, 1, 2, 12'h011, 8'hFF, 0, 0, 8'h00, 8'h00);
    add(0, 1, 1, 12'h010, 1, 2, 12'h011, 8'hFF, 1, 1, 8'h00, 8'h00);
    add(0, 0, 0, 12'h000, 0, 0, 12'h000, 8'hFF, 0, 0, 8'h03, 8'h06);
    add(0, 0, 0, 12'h000, 0, 0, 12'h000, 8'hFF, 0, 0, 8'h00, 8'h00);
    // Test 2: contested bank 3 alternates winners
    add(0, 1, 3, 12'h003, 1, 4, 12'h013, 8'hFF, 1, 0, 8'h00, 8'h00);
    add(0, 1, 3, 12'h003, 1, 4, 12'h013, 8'hFF, 0, 1, 8'h08, 8'h08);
    add(0, 1, 3, 12'h003, 1, 4, 12'h013, 8'hFF, 1, 0, 8'h08, 8'h10);
    add(0, 1, 3, 12'h003, 1, 4, 12'h013, 8'hFF, 0, 1, 8'h08, 8'h08);
    add(0, 0, 0, 12'h000, 0, 0, 12'h000, 8'hFF, 0, 0, 8'h08, 8'h10);
    add(0, 0, 0, 12'h000, 0, 0, 12'h000, 8'hFF, 0, 0, 8'h00, 8'h00);
    // Test 3: bank 5 stall then drain and refill together
    add(0, 1, 5, 12'h025, 0, 0, 12'h000, 8'hDF, 1, 0, 8'h00, 8'h00);
    add(0, 1, 6, 12'h035, 0, 0, 12'h000, 8'hDF, 0, 0, 8'h20, 8'h00);
    add(0, 1, 6, 12'h035, 0, 0, 12'h000, 8'hDF, 0, 0, 8'h20, 8'h00);
    add(0, 1, 6, 12'h035, 0, 0, 12'h000, 8'hDF, 0, 0, 8'h20, 8'h00);
    add(0, 1, 6, 12'h035, 0, 0, 12'h000, 8'hFF, 1, 0, 8'h20, 8'h20);
    add(0, 0, 0, 12'h000, 0, 0, 12'h000, 8'hFF, 0, 0, 8'h20, 8'h40);
    add(0, 0, 0, 12'h000, 0, 0, 12'h000, 8'hFF, 0, 0, 8'h00, 8'h00);
    // Test 4: ALU blocked on bank 2, MFPU streams to bank 6
    add(0, 1, 1, 12'h002, 1, 2, 12'h006, 8'hFB, 1, 1, 8'h00, 8'h00);
    add(0, 1, 1, 12'h012, 1, 3, 12'h016, 8'hFB, 0, 1, 8'h44, 8'h04);
    add(0, 1, 1, 12'h012, 1, 3, 12'h016, 8'hFB, 0, 1, 8'h44, 8'h08);
    add(0, 1, 1, 12'h012, 0, 0, 12'h000, 8'hFF, 1, 0, 8'h44, 8'h0A);
    add(0, 0, 0, 12'h000, 0, 0, 12'h000, 8'hFF, 0, 0, 8'h04, 8'h02);
    add(0, 0, 0, 12'h000, 0, 0, 12'h000, 8'hFF, 0, 0, 8'h00, 8'h00);
    // Test 5: reset with bank 4 full and its pointer moved to MFPU
    add(0, 1, 7, 12'h004, 1, 6, 12'h014, 8'hEF, 1, 0, 8'h00, 8'h00);
    add(0, 0, 0, 12'h000, 0, 0, 12'h000, 8'hEF, 0, 0, 8'h10, 8'h00);
    add(1, 1, 7, 12'h004, 1, 6, 12'h014, 8'hEF, 0, 0, 8'h10, 8'h00);
    add(0, 1, 7, 12'h004, 1, 6, 12'h014, 8'hFF, 1, 0, 8'h00, 8'h00);
    add(0, 0, 0, 12'h000, 0, 0, 12'h000, 8'hFF, 0, 0, 8'h10, 8'h80);
    add(0, 0, 0, 12'h000, 0, 0, 12'h000, 8'hFF, 0, 0, 8'h00, 8'h00);
    // Test 6: same ID committing on two banks at once
    add(0, 1, 2, 12'h008, 1, 2, 12'h00F, 8'hFF, 1, 1, 8'h00, 8'h00);
    add(0, 0, 0, 12'h000, 0, 0, 12'h000, 8'hFF, 0, 0, 8'h81, 8'h04);

    drive(1'b1, 1'b0, '0, '0, 8'hFF, 1'b0, '0, '0, 8'hFF);
    step();
    step();
    check("reset bank_req", 64'(bank_req), 64'h0);
    check("reset commit", 64'(commit), 64'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].a_req, vecs[i].a_id, vecs[i].a_addr, 8'hFF,
            vecs[i].m_req, vecs[i].m_id, vecs[i].m_addr, vecs[i].rdy);
      #3;
      check($sformatf("v%0d alu_gnt", i), 64'(a_gnt), 64'(vecs[i].e_ag));
      check($sformatf("v%0d mfpu_gnt", i), 64'(m_gnt), 64'(vecs[i].e_mg));
      check($sformatf("v%0d bank_req", i), 64'(bank_req), 64'(vecs[i].e_req));
      check($sformatf("v%0d commit", i), 64'(commit), 64'(vecs[i].e_commit));
      step();
    end

    // Row and data routing for the parallel case
    drive(1'b0, 1'b1, 3'd1, 12'h010, 8'hFF, 1'b1, 3'd2, 12'h011, 8'hFF);
    step();
    idle();
    #3;
    check("t1 row bank0", 64'(bank_addr[0]), 64'h2);
    check("t1 row bank1", 64'(bank_addr[1]), 64'h2);
    check("t1 data bank0", bank_data[0], 64'hA000_0000_0000_0010);
    check("t1 data bank1", bank_data[1], 64'hB000_0000_0000_0011);
    check("t1 be bank1", 64'(bank_be[1]), 64'hFF);
    step();

    // Stalled entry stays stable while a different request waits
    drive(1'b0, 1'b1, 3'd5, 12'h025, 8'hFF, 1'b0, '0, '0, 8'hDF);
    step();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b1, 3'd6, 12'h035, 8'h0F, 1'b0, '0, '0, 8'hDF);
      #3;
      check($sformatf("stall%0d gnt", c), 64'(a_gnt), 64'h0);
      check($sformatf("stall%0d row", c), 64'(bank_addr[5]), 64'h4);
      check($sformatf("stall%0d data", c), bank_data[5], 64'hA000_0000_0000_0025);
      check($sformatf("stall%0d be", c), 64'(bank_be[5]), 64'hFF);
      step();
    end
    drive(1'b0, 1'b1, 3'd6, 12'h035, 8'h0F, 1'b0, '0, '0, 8'hFF);
    #3;
    check("stall release gnt", 64'(a_gnt), 64'h1);
    check("stall release commit", 64'(commit), 64'h20);
    step();
    idle();
    #3;
    check("refill row", 64'(bank_addr[5]), 64'h6);
    check("refill be", 64'(bank_be[5]), 64'h0F);
    step();

    // Zero byte enables still write and commit
    drive(1'b0, 1'b1, 3'd5, 12'h001, 8'h00, 1'b0, '0, '0, 8'hFF);
    step();
    idle();
    #3;
    check("be0 bank_req", 64'(bank_req), 64'h02);
    check("be0 be", 64'(bank_be[1]), 64'h0);
    check("be0 commit", 64'(commit), 64'h20);
    step();
    #3;
    check("be0 drained", 64'(bank_req), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vrf_result_wb_arbiter.md
Name: vrf_result_wb_arbiter

Overview:
- Responder side of the lane FU result-write interface. Accepts `req`/`gnt` result writes from the vector ALU and the MFPU.
- Routes each write to one VRF bank, selected by the low address bits.
- Arbitrates with per-bank round-robin, buffers one write per bank, and applies per-bank backpressure.
- Reports committed writes per instruction ID back to the lane sequencer.

Parameters:
- NrBanks, 8, number of VRF banks per lane; power of two, at least 2.
- VaddrWidth, 12, width of the incoming result address.
- DataWidth, 64, element width (ELEN).
- NrVInsn, 8, number of instruction IDs; vid width is log2(NrVInsn).
- BankSelW, local = log2(NrBanks).
- RowW, local = VaddrWidth - BankSelW.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- alu_result_req_i  in  1  ALU write request
- alu_result_id_i  in  log2(NrVInsn)  ALU instruction ID
- alu_result_addr_i  in  VaddrWidth  ALU VRF address
- alu_result_wdata_i  in  DataWidth  ALU write data
- alu_result_be_i  in  DataWidth/8  ALU byte enables
- alu_result_gnt_o  out  1  ALU write accepted this cycle
- mfpu_result_req_i / _id_i / _addr_i / _wdata_i / _be_i  in  same widths  MFPU request fields
- mfpu_result_gnt_o  out  1  MFPU write accepted this cycle
- bank_wr_req_o  out  NrBanks  per-bank write valid
- bank_wr_addr_o  out  NrBanks x RowW  row address within the bank
- bank_wr_data_o  out  NrBanks x DataWidth  write data
- bank_wr_be_o  out  NrBanks x DataWidth/8  byte enables
- bank_wr_ready_i  in  NrBanks  bank accepts the write this cycle
- wr_commit_o  out  NrVInsn  bitmask of IDs that had a write commit this cycle

Behaviour:
- Reset (rst_i high at a clock edge):
  - All bank buffers become empty.
  - bank_wr_req_o = 0, wr_commit_o = 0.
  - All round-robin pointers reset to ALU priority.
  - Grants are 0 while rst_i is high.
- Reset mid-operation: buffered writes are dropped; requesters must re-issue.
- Bank selection: bank = addr[BankSelW-1:0], row = addr[VaddrWidth-1:BankSelW].
- Bank buffer: one entry per bank. The entry can load in a cycle when it is empty, or when it is full and bank_wr_ready_i[b] is high (drain and refill in the same cycle, giving full throughput).
- Grant is combinational in the request cycle:
  - gnt is high iff req is high, the target bank's entry can load, and the requester wins arbitration for that bank.
  - Requesters hold their request fields stable until gnt; the arbiter does not require this for correctness.
- Arbitration:
  - If ALU and MFPU target different banks, both are granted in the same cycle.
  - If they target the same bank, the winner is given by rr_ptr[b] (0 = ALU, 1 = MFPU).
  - After every contested grant, rr_ptr[b] flips to the loser. Uncontested grants leave the pointer unchanged.
- Latency: a granted write appears on bank_wr_req_o[b] at the next cycle. The entry holds data, row, be and id stable until bank_wr_ready_i[b] is high.
- Commit: in the cycle bank_wr_req_o[b] && bank_wr_ready_i[b], bit id of wr_commit_o is set. Multiple banks may commit in one cycle; their bits are ORed.
- Stall: while a bank is full and not ready, any requester targeting it gets gnt = 0. The other requester proceeds if its target bank is free.
- be = 0: still written and committed; no special case.
- bank_wr_ready_i high while the entry is empty is ignored.

Decomposition:
- Shared package (ara_pkg):
  - vid_t
  - the result-write request struct {id, addr, wdata, be}
  - the bank write struct {row, data, be, id}
- Sub-module vrf_wb_bank_slot: a one-entry buffer with load/drain handshake and the per-bank 2-way round-robin pointer, instantiated NrBanks times. The top level holds address decode, grant muxing and the commit OR.

Test Plan:
1. ALU addr 0x010 (bank 0) and MFPU addr 0x011 (bank 1) in the same cycle, all banks ready → both gnt = 1; the next cycle bank_wr_req_o = 0b00000011 with rows 0x002 and 0x002; wr_commit_o shows both IDs.
2. Both request bank 3 for 4 consecutive cycles, ready always high, after reset → grant order ALU, MFPU, ALU, MFPU; one write per cycle on bank 3.
3. Bank 5 ready = 0 for 3 cycles, ALU targets bank 5 → first request granted, next 3 cycles gnt = 0 with the entry held stable; when ready rises, commit and a new grant occur in the same cycle.
4. Bank 2 stalled with ALU blocked on it, MFPU targets bank 6 → MFPU granted every cycle while the ALU stays blocked.
5. Entry in bank 4 full, rst_i pulsed for 1 cycle → bank_wr_req_o = 0 afterwards, no commit, rr_ptr back to ALU.
6. ID 2 writes to banks 0 and 7 committing in the same cycle → wr_commit_o = 0b00000100.
